// File: rtl/render_pkg.sv
// Shared constants for the raster renderer: screen geometry, palette and FSM encoding.
package render_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int GROUND_Y    = 100;
  localparam int LANE_H      = 10;
  localparam int PLAYER_X    = 20;
  localparam int PLAYER_SIZE = 8;

  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_shader.sv
// Combinational colour of one pixel from the frame snapshot; player beats obstacles beats ground.
module pixel_shader
  import render_pkg::*;
(
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  input  logic [SCREEN_W-1:0] lane0,
  input  logic [SCREEN_W-1:0] lane1,
  input  logic [4:0]          height,
  input  logic                dead,
  output logic [2:0]          colour
);

  localparam logic [7:0] PX_LO  = 8'(PLAYER_X);
  localparam logic [7:0] PX_HI  = 8'(PLAYER_X + PLAYER_SIZE - 1);
  localparam logic [7:0] PY_TOP = 8'(GROUND_Y - PLAYER_SIZE);
  localparam logic [7:0] PY_BOT = 8'(GROUND_Y - 1);
  localparam logic [7:0] L0_TOP = 8'(GROUND_Y - LANE_H);
  localparam logic [7:0] L0_BOT = 8'(GROUND_Y - 1);
  localparam logic [7:0] L1_TOP = 8'(GROUND_Y - 2*LANE_H);
  localparam logic [7:0] L1_BOT = 8'(GROUND_Y - LANE_H - 1);
  localparam logic [7:0] GND    = 8'(GROUND_Y);

  logic [7:0] row;
  logic [7:0] p_top;
  logic [7:0] p_bot;
  logic       in_player;
  logic       in_lane0;
  logic       in_lane1;

  // Sprite rises with height; geometry check in the top keeps these from wrapping.
  assign row       = {1'b0, y};
  assign p_top     = PY_TOP - {3'b000, height};
  assign p_bot     = PY_BOT - {3'b000, height};
  assign in_player = (x >= PX_LO) && (x <= PX_HI) && (row >= p_top) && (row <= p_bot);
  assign in_lane0  = lane0[x] && (row >= L0_TOP) && (row <= L0_BOT);
  assign in_lane1  = lane1[x] && (row >= L1_TOP) && (row <= L1_BOT);

  always_comb begin
    colour = COL_BLACK;
    if (in_player)       colour = dead ? COL_MAGENTA : COL_GREEN;
    else if (in_lane0)   colour = COL_RED;
    else if (in_lane1)   colour = COL_RED;
    else if (row >= GND) colour = COL_WHITE;
  end

endmodule

// File: rtl/frame_renderer.sv
// Sweeps the framebuffer once per start request and streams registered pixel writes to the VGA adapter.
module frame_renderer
  import render_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [SCREEN_W-1:0] lane0,
  input  logic [SCREEN_W-1:0] lane1,
  input  logic [4:0]          height,
  input  logic                dead,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [2:0]          colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  if (GROUND_Y < PLAYER_SIZE + 31 || GROUND_Y < 2*LANE_H) begin : g_bad_geometry
    $error("frame_renderer: row bounds would underflow");
  end

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  state_t              state;
  state_t              state_next;
  logic [7:0]          cnt_x;
  logic [6:0]          cnt_y;
  logic                last_pix;
  logic [SCREEN_W-1:0] snap_lane0;
  logic [SCREEN_W-1:0] snap_lane1;
  logic [4:0]          snap_height;
  logic                snap_dead;
  logic [7:0]          s1_x;
  logic [6:0]          s1_y;
  logic                s1_valid;
  logic [2:0]          shade;

  assign last_pix = (cnt_x == X_LAST) && (cnt_y == Y_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (last_pix) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_x       <= '0;
      cnt_y       <= '0;
      snap_lane0  <= '0;
      snap_lane1  <= '0;
      snap_height <= '0;
      snap_dead   <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt_x       <= '0;
      cnt_y       <= '0;
      snap_lane0  <= lane0;
      snap_lane1  <= lane1;
      snap_height <= height;
      snap_dead   <= dead;
    end else if (state == SCAN && !last_pix) begin
      if (cnt_x == X_LAST) begin
        cnt_x <= '0;
        cnt_y <= cnt_y + 7'd1;
      end else begin
        cnt_x <= cnt_x + 8'd1;
      end
    end
  end

  // Coordinate stage: the shader evaluates this, then the result is registered to the adapter.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_x     <= '0;
      s1_y     <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_x     <= cnt_x;
      s1_y     <= cnt_y;
      s1_valid <= (state == SCAN);
    end
  end

  pixel_shader u_shader (
    .x      (s1_x),
    .y      (s1_y),
    .lane0  (snap_lane0),
    .lane1  (snap_lane1),
    .height (snap_height),
    .dead   (snap_dead),
    .colour (shade)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= COL_BLACK;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      x      <= s1_valid ? s1_x : 8'd0;
      y      <= s1_valid ? s1_y : 7'd0;
      colour <= s1_valid ? shade : COL_BLACK;
      plot   <= s1_valid;
      busy   <= (state == SCAN) || (state == FLUSH);
      done   <= (state == DONE);
    end
  end

endmodule
